debug_step_ctrl: RTL and testbench
==================================

# debug_step_ctrl

Multicore debug controller that sequences per-core clock enables for run, halt, N-cycle step and PC breakpoint. It sits between the host software-register interface and the core array. Each core's clock enable is driven from a registered per-core state, replacing free-running clock gating with a deterministic, command-driven scheduler. One command port is shared by all cores through a core mask.

## Interface
- NUM_CORES, 4, number of cores controlled
- PC_WIDTH, 10, core PC width (instruction memory address width)
- STEP_WIDTH, 8, step count width
- clk_in  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 RUN, 01 HALT, 10 STEP, 11 SET_BP
- cmd_core_mask  in  NUM_CORES  target cores for RUN/HALT/STEP; ignored for SET_BP
- cmd_arg  in  STEP_WIDTH  STEP: cycle count; SET_BP: bit0 = breakpoint enable
- cmd_pc  in  PC_WIDTH  SET_BP: breakpoint address
- core_pc  in  NUM_CORES*PC_WIDTH  current PC per core; core i at [i*PC_WIDTH +: PC_WIDTH]
- core_clk_en  out  NUM_CORES  per-core clock enable
- halted  out  NUM_CORES  core in HALT state
- bp_hit  out  NUM_CORES  sticky breakpoint-hit flag per core
- busy  out  1  at least one core in STEP

## Operation
- Per-core state machine: RUN, HALT, STEP. core_clk_en[i] = (state==RUN)|(state==STEP), decoded from the state register only. halted[i] = (state==HALT).
- Reset (rst_n=0 at an edge): all cores RUN, step counters 0, bp_addr 0, bp_en 0, bp_hit 0, bp_skip 0. After reset: core_clk_en all 1, halted 0, busy 0, cmd_ready 1.
- cmd_ready = ~busy. No command is accepted while any core is stepping.
- RUN: every masked core in HALT goes to RUN. Its bp_hit is cleared and bp_skip is set. Masked cores already in RUN are unchanged.
- HALT: every masked core in RUN goes to HALT.
- STEP with cmd_arg=N>0: every masked core in HALT loads count=N, clears bp_hit and goes to STEP. Masked cores in RUN ignore the command.
- STEP with N=0: accepted as a no-op.
- STEP state: the core is enabled for exactly N cycles. Count decrements each STEP cycle. When count==1 the core moves to HALT and count becomes 0.
- SET_BP: bp_addr<=cmd_pc, bp_en<=cmd_arg[0]. This is a global breakpoint shared by all cores. Core states are unchanged.
- Breakpoint: a core in RUN with bp_en=1, bp_skip=0 and core_pc==bp_addr goes to HALT and sets bp_hit.
- bp_skip: cleared after the core's first RUN cycle. This prevents re-halting at the address the core was resumed from.
- Breakpoints are not evaluated in STEP or HALT.
- Simultaneous HALT command and breakpoint on the same core: result is HALT and bp_hit is set.
- RUN command in the same cycle as a breakpoint match on a core already in RUN: the breakpoint wins (HALT, bp_hit set) and the RUN is a no-op for that core.
- A masked core's transition depends only on its own current state. One command can therefore move some cores and leave others unchanged.
- Reset mid-STEP: the step is aborted, all cores go to RUN, and cmd_ready=1 on the next cycle.

## Timing
- A command accepted at edge T updates state at T. core_clk_en, halted and busy reflect the new state in the cycle following T (one-cycle latency).
- STEP N: core_clk_en is high for exactly N consecutive cycles starting the cycle after acceptance. busy is high for the same N cycles. cmd_ready returns high the cycle after the last enabled cycle.
- Breakpoint: a match sampled at edge T drops core_clk_en from the cycle after T, so the core executes the matching cycle's edge and is not enabled again.
- bp_hit rises in the same cycle halted rises.
- cmd_pc, cmd_arg and cmd_core_mask are sampled only at the accepting edge.

## Test plan
- Reset, then idle 5 cycles -> core_clk_en=4'b1111, halted=0, busy=0, cmd_ready=1, bp_hit=0.
- HALT mask 4'b0101, then STEP mask 4'b0111 arg 3 -> cores 0 and 2 enabled exactly 3 cycles, then halted. Core 1 stays RUN. busy high 3 cycles. cmd_ready low during those cycles; a cmd_valid asserted meanwhile is not accepted.
- SET_BP pc=0x040 en=1, core 1 PC reaches 0x040 -> core_clk_en[1]=0 the next cycle, bp_hit[1]=1, other cores unaffected. A following RUN mask 4'b0010 with PC still 0x040 -> core 1 resumes and does not re-halt; bp_hit[1] is cleared.
- STEP arg 0 on a halted core -> accepted, busy stays 0, core stays halted. STEP on a running core -> no change.
- HALT command coincident with a breakpoint match on core 3 -> core 3 halted with bp_hit[3]=1.
- Assert rst_n=0 during STEP arg 200 at cycle 50 -> next cycle all core_clk_en=1, busy=0, bp_en cleared.

Source files
------------

// File: rtl/debug_step_ctrl_if.sv
// Host command channel of the debug step controller: a single valid/ready port
// whose RUN/HALT/STEP commands are steered to cores by a mask.
interface debug_step_ctrl_if #(
  parameter int NUM_CORES  = 4,
  parameter int PC_WIDTH   = 10,
  parameter int STEP_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [NUM_CORES-1:0]  cmd_core_mask;
  logic [STEP_WIDTH-1:0] cmd_arg;
  logic [PC_WIDTH-1:0]   cmd_pc;

  modport master (
    output cmd_valid, cmd_op, cmd_core_mask, cmd_arg, cmd_pc,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_core_mask, cmd_arg, cmd_pc,
    output cmd_ready
  );
endinterface

// File: rtl/debug_step_ctrl.sv
// Multicore debug scheduler: per-core RUN/HALT/STEP state drives each core's
// clock enable, with a shared PC breakpoint and a masked command port.
module debug_step_core #(
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  run_cmd,
  input  logic                  halt_cmd,
  input  logic                  step_cmd,
  input  logic [STEP_WIDTH-1:0] step_n,
  input  logic                  bp_match,
  output logic                  clk_en,
  output logic                  halted,
  output logic                  stepping,
  output logic                  bp_hit
);
  typedef enum logic [1:0] {S_RUN = 2'd0, S_HALT = 2'd1, S_STEP = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] cnt_q, cnt_d;
  logic                  hit_q, hit_d;
  logic                  skip_q, skip_d;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    skip_d  = skip_q;
    unique case (state_q)
      S_RUN: begin
        // skip only masks the first RUN cycle after a resume
        skip_d = 1'b0;
        if (bp_match && !skip_q) begin
          state_d = S_HALT;
          hit_d   = 1'b1;
        end else if (halt_cmd) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (run_cmd) begin
          state_d = S_RUN;
          hit_d   = 1'b0;
          skip_d  = 1'b1;
        end else if (step_cmd && (step_n != '0)) begin
          state_d = S_STEP;
          cnt_d   = step_n;
          hit_d   = 1'b0;
        end
      end
      S_STEP: begin
        if (cnt_q <= {{(STEP_WIDTH-1){1'b0}}, 1'b1}) begin
          state_d = S_HALT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign clk_en   = (state_q == S_RUN) || (state_q == S_STEP);
  assign halted   = (state_q == S_HALT);
  assign stepping = (state_q == S_STEP);
  assign bp_hit   = hit_q;
endmodule

module debug_step_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int PC_WIDTH   = 10,
  parameter int STEP_WIDTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  debug_step_ctrl_if.slave              cmd,
  input  logic [NUM_CORES*PC_WIDTH-1:0] core_pc,
  output logic [NUM_CORES-1:0]          core_clk_en,
  output logic [NUM_CORES-1:0]          halted,
  output logic [NUM_CORES-1:0]          bp_hit,
  output logic                          busy
);
  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_HALT  = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_SETBP = 2'b11;

  typedef struct packed {
    logic                en;
    logic [PC_WIDTH-1:0] addr;
  } bp_t;

  bp_t                  bp_q;
  logic                 cmd_fire;
  logic [NUM_CORES-1:0] stepping;
  logic [NUM_CORES-1:0] run_cmd, halt_cmd, step_cmd, bp_match;

  assign busy          = |stepping;
  assign cmd.cmd_ready = ~busy;
  assign cmd_fire      = cmd.cmd_valid & ~busy;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      bp_q <= '0;
    end else if (cmd_fire && cmd.cmd_op == OP_SETBP) begin
      bp_q.addr <= cmd.cmd_pc;
      bp_q.en   <= cmd.cmd_arg[0];
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign run_cmd[i]  = cmd_fire && cmd.cmd_core_mask[i] && (cmd.cmd_op == OP_RUN);
    assign halt_cmd[i] = cmd_fire && cmd.cmd_core_mask[i] && (cmd.cmd_op == OP_HALT);
    assign step_cmd[i] = cmd_fire && cmd.cmd_core_mask[i] && (cmd.cmd_op == OP_STEP);
    assign bp_match[i] = bp_q.en && (core_pc[i*PC_WIDTH +: PC_WIDTH] == bp_q.addr);

    debug_step_core #(.STEP_WIDTH(STEP_WIDTH)) u_core (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .run_cmd  (run_cmd[i]),
      .halt_cmd (halt_cmd[i]),
      .step_cmd (step_cmd[i]),
      .step_n   (cmd.cmd_arg),
      .bp_match (bp_match[i]),
      .clk_en   (core_clk_en[i]),
      .halted   (halted[i]),
      .stepping (stepping[i]),
      .bp_hit   (bp_hit[i])
    );
  end
endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: directed vector table, hand-written corner
// sequences and a randomized run checked against a behavioural model.
module tb_debug_step_ctrl;
  localparam int NC = 4;
  localparam int PW = 10;
  localparam int SW = 8;

  logic             clk_in = 1'b0;
  logic             rst_n;
  logic [NC*PW-1:0] core_pc;
  logic [NC-1:0]    core_clk_en, halted, bp_hit;
  logic             busy;
  logic [PW-1:0]    pcs [NC];

  int n_tests = 0;
  int n_fail  = 0;

  debug_step_ctrl_if #(.NUM_CORES(NC), .PC_WIDTH(PW), .STEP_WIDTH(SW)) cmd_if ();

  debug_step_ctrl #(.NUM_CORES(NC), .PC_WIDTH(PW), .STEP_WIDTH(SW)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .core_pc     (core_pc),
    .core_clk_en (core_clk_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  always_comb begin
    core_pc = '0;
    for (int i = 0; i < NC; i++) core_pc[i*PW +: PW] = pcs[i];
  end

  // Behavioural model: a core is running, halted, or has steps_left cycles to go.
  bit            m_run  [NC];
  int            m_left [NC];
  bit            m_hit  [NC];
  bit            m_skip [NC];
  bit            m_bp_en;
  logic [PW-1:0] m_bp_addr;

  function automatic bit m_busy();
    for (int i = 0; i < NC; i++) if (m_left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit acc;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        m_run[i] = 1; m_left[i] = 0; m_hit[i] = 0; m_skip[i] = 0;
      end
      m_bp_en = 0; m_bp_addr = '0;
      return;
    end
    acc = cmd_if.cmd_valid && !m_busy();
    for (int i = 0; i < NC; i++) begin
      bit sel;
      sel = acc && cmd_if.cmd_core_mask[i];
      if (m_left[i] > 0) begin
        m_left[i]--;
      end else if (m_run[i]) begin
        bit brk;
        brk = m_bp_en && !m_skip[i] && (pcs[i] == m_bp_addr);
        m_skip[i] = 0;
        if (brk) begin m_run[i] = 0; m_hit[i] = 1; end
        else if (sel && cmd_if.cmd_op == 2'd1) m_run[i] = 0;
      end else begin
        if (sel && cmd_if.cmd_op == 2'd0) begin
          m_run[i] = 1; m_hit[i] = 0; m_skip[i] = 1;
        end else if (sel && cmd_if.cmd_op == 2'd2 && cmd_if.cmd_arg != 0) begin
          m_left[i] = int'(cmd_if.cmd_arg); m_hit[i] = 0;
        end
      end
    end
    if (acc && cmd_if.cmd_op == 2'd3) begin
      m_bp_en = cmd_if.cmd_arg[0]; m_bp_addr = cmd_if.cmd_pc;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NC-1:0] e_en, e_h, e_hit;
    for (int i = 0; i < NC; i++) begin
      e_en[i]  = m_run[i] || (m_left[i] > 0);
      e_h[i]   = !m_run[i] && (m_left[i] == 0);
      e_hit[i] = m_hit[i];
    end
    chk({tag, ".clk_en"}, 32'(core_clk_en), 32'(e_en));
    chk({tag, ".halted"}, 32'(halted), 32'(e_h));
    chk({tag, ".bp_hit"}, 32'(bp_hit), 32'(e_hit));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy()));
    chk({tag, ".ready"}, 32'(cmd_if.cmd_ready), 32'(!m_busy()));
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [NC-1:0] m,
                       input logic [SW-1:0] arg, input logic [PW-1:0] pc);
    cmd_if.cmd_valid = v; cmd_if.cmd_op = op; cmd_if.cmd_core_mask = m;
    cmd_if.cmd_arg = arg; cmd_if.cmd_pc = pc;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, '0, '0, '0);
  endtask

  // One clock: model consumes the inputs present at the edge, outputs checked 1ns later.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk_in); #1;
    check_model(tag);
  endtask

  typedef struct {
    bit            vld;
    logic [1:0]    op;
    logic [NC-1:0] mask;
    logic [SW-1:0] arg;
    logic [NC-1:0] e_en;
    logic [NC-1:0] e_halt;
    bit            e_busy;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(bit v, logic [1:0] op, logic [NC-1:0] m, logic [SW-1:0] a,
                              logic [NC-1:0] en, logic [NC-1:0] h, bit b);
    vec_t r;
    r.vld = v; r.op = op; r.mask = m; r.arg = a; r.e_en = en; r.e_halt = h; r.e_busy = b;
    return r;
  endfunction

  initial begin
    tbl[0]  = mk(0, 2'd0, 4'b0000, 8'd0, 4'b1111, 4'b0000, 0); // idle
    tbl[1]  = mk(1, 2'd1, 4'b0101, 8'd0, 4'b1010, 4'b0101, 0); // HALT 0,2
    tbl[2]  = mk(1, 2'd2, 4'b0111, 8'd3, 4'b1111, 4'b0000, 1); // STEP 3
    tbl[3]  = mk(1, 2'd1, 4'b1111, 8'd0, 4'b1111, 4'b0000, 1); // refused while busy
    tbl[4]  = mk(0, 2'd0, 4'b0000, 8'd0, 4'b1111, 4'b0000, 1);
    tbl[5]  = mk(0, 2'd0, 4'b0000, 8'd0, 4'b1010, 4'b0101, 0); // step done
    tbl[6]  = mk(1, 2'd2, 4'b0001, 8'd0, 4'b1010, 4'b0101, 0); // STEP 0 no-op
    tbl[7]  = mk(1, 2'd2, 4'b0010, 8'd5, 4'b1010, 4'b0101, 0); // STEP on running core
    tbl[8]  = mk(1, 2'd0, 4'b1111, 8'd0, 4'b1111, 4'b0000, 0); // RUN all
    tbl[9]  = mk(1, 2'd2, 4'b1111, 8'd1, 4'b1111, 4'b0000, 0); // STEP all running
    tbl[10] = mk(1, 2'd1, 4'b1000, 8'd0, 4'b0111, 4'b1000, 0);
    tbl[11] = mk(1, 2'd2, 4'b1000, 8'd1, 4'b1111, 4'b0000, 1); // STEP 1
    tbl[12] = mk(0, 2'd0, 4'b0000, 8'd0, 4'b0111, 4'b1000, 0);

    for (int i = 0; i < NC; i++) pcs[i] = 10'h3FF;
    idle();
    rst_n = 1'b0;
    cycle("rst");
    cycle("rst");
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cycle("idle");
    chk("reset.clk_en", 32'(core_clk_en), 32'hF);
    chk("reset.halted", 32'(halted), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("reset.bp_hit", 32'(bp_hit), 32'h0);

    for (int v = 0; v < 13; v++) begin
      drive(tbl[v].vld, tbl[v].op, tbl[v].mask, tbl[v].arg, '0);
      cycle("tbl");
      chk($sformatf("tbl%0d.clk_en", v), 32'(core_clk_en), 32'(tbl[v].e_en));
      chk($sformatf("tbl%0d.halted", v), 32'(halted), 32'(tbl[v].e_halt));
      chk($sformatf("tbl%0d.busy", v), 32'(busy), 32'(tbl[v].e_busy));
      chk($sformatf("tbl%0d.ready", v), 32'(cmd_if.cmd_ready), 32'(!tbl[v].e_busy));
      chk($sformatf("tbl%0d.bp_hit", v), 32'(bp_hit), 32'h0);
    end

    // breakpoint hit, then resume at the same PC without re-halting
    drive(1, 2'd0, 4'b1111, 8'd0, '0);       cycle("bp.run");
    drive(1, 2'd3, 4'b0000, 8'd1, 10'h040);  cycle("bp.set");
    idle(); pcs[1] = 10'h040;                cycle("bp.hit");
    chk("bp.hit.clk_en", 32'(core_clk_en), 32'hD);
    chk("bp.hit.bp_hit", 32'(bp_hit), 32'h2);
    chk("bp.hit.halted", 32'(halted), 32'h2);
    drive(1, 2'd0, 4'b0010, 8'd0, '0);       cycle("bp.resume");
    chk("bp.resume.clk_en", 32'(core_clk_en), 32'hF);
    chk("bp.resume.bp_hit", 32'(bp_hit), 32'h0);
    idle();                                  cycle("bp.skip");
    chk("bp.skip.clk_en", 32'(core_clk_en), 32'hF);
    pcs[1] = 10'h041;                        cycle("bp.moved");

    // HALT coincident with a breakpoint; RUN coincident with a breakpoint
    pcs[3] = 10'h040; drive(1, 2'd1, 4'b1000, 8'd0, '0); cycle("bp.halt3");
    chk("bp.halt3.halted", 32'(halted), 32'h8);
    chk("bp.halt3.bp_hit", 32'(bp_hit), 32'h8);
    pcs[3] = 10'h3FF; pcs[2] = 10'h040;
    drive(1, 2'd0, 4'b0100, 8'd0, '0);       cycle("bp.run2");
    chk("bp.run2.halted", 32'(halted), 32'hC);
    chk("bp.run2.bp_hit", 32'(bp_hit), 32'hC);
    pcs[2] = 10'h3FF;

    // reset in the middle of a long step
    drive(1, 2'd1, 4'b1111, 8'd0, '0);       cycle("rs.halt");
    drive(1, 2'd2, 4'b1111, 8'd200, '0);     cycle("rs.step");
    idle();
    for (int k = 0; k < 45; k++) cycle("rs.busy");
    chk("rs.busy_mid", 32'(busy), 32'h1);
    rst_n = 1'b0;                            cycle("rs.reset");
    rst_n = 1'b1;
    chk("rs.clk_en", 32'(core_clk_en), 32'hF);
    chk("rs.busy", 32'(busy), 32'h0);
    chk("rs.ready", 32'(cmd_if.cmd_ready), 32'h1);
    chk("rs.bp_hit", 32'(bp_hit), 32'h0);
    pcs[0] = 10'h040; pcs[1] = 10'h000;
    for (int k = 0; k < 3; k++) cycle("rs.bpoff");
    chk("rs.bpoff.clk_en", 32'(core_clk_en), 32'hF);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      logic [PW-1:0] pool [3];
      pool[0] = 10'h040; pool[1] = 10'h041; pool[2] = 10'h0A0;
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < NC; i++) pcs[i] = pool[$urandom_range(0, 2)];
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 4'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6)),
            pool[$urandom_range(0, 2)]);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
